vga_timing_gen: RTL

//  Parametrised raster timing generator; successor to the fixed 640x480 col/row counter block.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_timing_gen_raster_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared raster timing description for the VGA timing generator.
//   timing_t  : one axis of a raster (active, front porch, sync, back porch)
//   total()   : full period of one axis in pixels or lines
//   VGA_640x480_H / VGA_640x480_V : standard 640x480@60 axis timings
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    localparam timing_t VGA_640x480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam timing_t VGA_640x480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
//   Column/row position pair walking a COL_TOTAL x ROW_TOTAL raster.
//   While enable is low the next position is the load value (LOAD_COL,
//   LOAD_ROW); reset also returns to the load value.
//   Ports:
//     PxClock   in   pixel clock, rising edge
//     Reset     in   asynchronous, active-high
//     enable    in   1: advance one position per clock, 0: (re)load
//     col_next  out  next column, right-shifted by SHIFT
//     row_next  out  next row, right-shifted by SHIFT
//   The outputs are the position the counter moves to on the coming edge,
//   so the parent can register decoded values in step with the counter.
// ---------------------------------------------------------------------------
module raster_counter #(
    parameter int CNT_W     = 10,
    parameter int COL_TOTAL = 800,
    parameter int ROW_TOTAL = 525,
    parameter int LOAD_COL  = 0,
    parameter int LOAD_ROW  = 0,
    parameter int SHIFT     = 0
) (
    input  logic                     PxClock,
    input  logic                     Reset,
    input  logic                     enable,
    output logic [CNT_W-SHIFT-1:0]   col_next,
    output logic [CNT_W-SHIFT-1:0]   row_next
);

    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COL_TOTAL - 1);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ROW_TOTAL - 1);
    localparam logic [CNT_W-1:0] COL_LOAD  = CNT_W'(LOAD_COL);
    localparam logic [CNT_W-1:0] ROW_LOAD  = CNT_W'(LOAD_ROW);

    logic [CNT_W-1:0] col_reg, row_reg;
    logic [CNT_W-1:0] col_full_next, row_full_next;

    always_comb begin
        col_full_next = COL_LOAD;
        row_full_next = ROW_LOAD;
        if (enable) begin
            if (col_reg == COL_LAST) begin
                col_full_next = '0;
                row_full_next = (row_reg == ROW_LAST) ? '0 : row_reg + CNT_W'(1);
            end else begin
                col_full_next = col_reg + CNT_W'(1);
                row_full_next = row_reg;
            end
        end
    end

    always_ff @(posedge PxClock or posedge Reset) begin
        if (Reset) begin
            col_reg <= COL_LOAD;
            row_reg <= ROW_LOAD;
        end else begin
            col_reg <= col_full_next;
            row_reg <= row_full_next;
        end
    end

    assign col_next = col_full_next[CNT_W-1:SHIFT];
    assign row_next = row_full_next[CNT_W-1:SHIFT];

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator with sync/blank decode, NMI and
//   frame-swap strobes, frame counter and a prefetch framebuffer address.
//   Ports:
//     PxClock      in   pixel clock
//     Reset        in   asynchronous, active-high
//     Enable       in   0: counters held at (0,0), strobes suppressed
//     Col, Row     out  current raster position
//     HSync/VSync  out  sync levels (polarity HS_POL / VS_POL)
//     HBlank/VBlank out blanking flags
//     DispEn       out  visible pixel and Enable
//     LineEnd      out  pulse on the last column of every line
//     VBlankStart  out  pulse at (0, V_ACTIVE)
//     FrameCount   out  frame counter, modulo 2^FC_W
//     FetchAddr    out  {FRow>>SCALE, FCol>>SCALE}, PREFETCH pixels ahead
//   Every output is registered from the counters' next position, so all of
//   them line up with Col/Row in the same cycle.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640x480_H.active,
    parameter int H_FP     = VGA_640x480_H.fp,
    parameter int H_SYNC   = VGA_640x480_H.sync,
    parameter int H_BP     = VGA_640x480_H.bp,
    parameter int V_ACTIVE = VGA_640x480_V.active,
    parameter int V_FP     = VGA_640x480_V.fp,
    parameter int V_SYNC   = VGA_640x480_V.sync,
    parameter int V_BP     = VGA_640x480_V.bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int SCALE    = 2,
    parameter int PREFETCH = 2,
    parameter int CNT_W    = 10,
    parameter int FC_W     = 8
) (
    input  logic                         PxClock,
    input  logic                         Reset,
    input  logic                         Enable,
    output logic [CNT_W-1:0]             Col,
    output logic [CNT_W-1:0]             Row,
    output logic                         HSync,
    output logic                         VSync,
    output logic                         HBlank,
    output logic                         VBlank,
    output logic                         DispEn,
    output logic                         LineEnd,
    output logic                         VBlankStart,
    output logic [FC_W-1:0]              FrameCount,
    output logic [2*CNT_W-2*SCALE-1:0]   FetchAddr
);

    localparam timing_t H_TIM   = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t V_TIM   = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int      H_TOTAL = total(H_TIM);
    localparam int      V_TOTAL = total(V_TIM);
    localparam int      AW      = 2*CNT_W - 2*SCALE;

    // Decode thresholds carry one extra bit so a range ending exactly at
    // 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0]   H_ACT_X    = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   HS_START_X = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END_X   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   V_ACT_X    = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   VS_START_X = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END_X   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W:0]   H_LAST_X   = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [AW-1:0]    FETCH_RST  = AW'(PREFETCH >> SCALE);

    if (PREFETCH < 0 || PREFETCH >= H_TOTAL - H_ACTIVE ||
        H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W || SCALE >= CNT_W) begin : g_param_check
        $error("vga_timing_gen: PREFETCH must be below the horizontal blank width and totals must fit CNT_W");
    end

    logic [CNT_W-1:0]       col_next, row_next;
    logic [CNT_W-SCALE-1:0] fcol_next, frow_next;
    logic [CNT_W:0]         col_ext, row_ext;

    logic [CNT_W-1:0]       col_reg, row_reg;
    logic                   hsync_reg, vsync_reg, hblank_reg, vblank_reg;
    logic                   disp_en_reg, line_end_reg, vblank_start_reg;
    logic [FC_W-1:0]        frame_count_reg;
    logic [AW-1:0]          fetch_addr_reg;

    logic                   hsync_next, vsync_next, hblank_next, vblank_next;
    logic                   disp_en_next, line_end_next, vblank_start_next;
    logic                   frame_wrap;

    raster_counter #(
        .CNT_W(CNT_W), .COL_TOTAL(H_TOTAL), .ROW_TOTAL(V_TOTAL),
        .LOAD_COL(0), .LOAD_ROW(0), .SHIFT(0)
    ) u_display_cnt (
        .PxClock (PxClock),
        .Reset   (Reset),
        .enable  (Enable),
        .col_next(col_next),
        .row_next(row_next)
    );

    // Fetch counters run the same raster offset by PREFETCH pixels; the
    // offset survives line and frame wraps because both pairs wrap alike.
    raster_counter #(
        .CNT_W(CNT_W), .COL_TOTAL(H_TOTAL), .ROW_TOTAL(V_TOTAL),
        .LOAD_COL(PREFETCH), .LOAD_ROW(0), .SHIFT(SCALE)
    ) u_fetch_cnt (
        .PxClock (PxClock),
        .Reset   (Reset),
        .enable  (Enable),
        .col_next(fcol_next),
        .row_next(frow_next)
    );

    assign col_ext = {1'b0, col_next};
    assign row_ext = {1'b0, row_next};

    always_comb begin
        hsync_next        = (Enable && col_ext >= HS_START_X && col_ext < HS_END_X) ? HS_POL : ~HS_POL;
        // Row only changes together with Col returning to 0, so VSync
        // follows whole lines without extra qualification.
        vsync_next        = (Enable && row_ext >= VS_START_X && row_ext < VS_END_X) ? VS_POL : ~VS_POL;
        hblank_next       = (col_ext >= H_ACT_X);
        vblank_next       = (row_ext >= V_ACT_X);
        disp_en_next      = Enable && !hblank_next && !vblank_next;
        line_end_next     = Enable && (col_ext == H_LAST_X);
        vblank_start_next = Enable && (col_next == '0) && (row_ext == V_ACT_X);
        frame_wrap        = Enable && (col_reg == H_LAST) && (row_reg == V_LAST);
    end

    always_ff @(posedge PxClock or posedge Reset) begin
        if (Reset) begin
            col_reg          <= '0;
            row_reg          <= '0;
            hsync_reg        <= ~HS_POL;
            vsync_reg        <= ~VS_POL;
            hblank_reg       <= 1'b0;
            vblank_reg       <= 1'b0;
            disp_en_reg      <= 1'b0;
            line_end_reg     <= 1'b0;
            vblank_start_reg <= 1'b0;
            frame_count_reg  <= '0;
            fetch_addr_reg   <= FETCH_RST;
        end else begin
            col_reg          <= col_next;
            row_reg          <= row_next;
            hsync_reg        <= hsync_next;
            vsync_reg        <= vsync_next;
            hblank_reg       <= hblank_next;
            vblank_reg       <= vblank_next;
            disp_en_reg      <= disp_en_next;
            line_end_reg     <= line_end_next;
            vblank_start_reg <= vblank_start_next;
            fetch_addr_reg   <= {frow_next, fcol_next};
            if (frame_wrap) begin
                frame_count_reg <= frame_count_reg + FC_W'(1);
            end
        end
    end

    assign Col         = col_reg;
    assign Row         = row_reg;
    assign HSync       = hsync_reg;
    assign VSync       = vsync_reg;
    assign HBlank      = hblank_reg;
    assign VBlank      = vblank_reg;
    assign DispEn      = disp_en_reg;
    assign LineEnd     = line_end_reg;
    assign VBlankStart = vblank_start_reg;
    assign FrameCount  = frame_count_reg;
    assign FetchAddr   = fetch_addr_reg;

endmodule
